// File: rtl/booth_radix4_mul_seq_if.sv
// Start/done handshake bundle for the radix-4 Booth sequential multiplier.
// The ALU sequencer (master) drives the request and operands; the multiplier (slave) returns status and result.
interface booth_radix4_mul_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      enable_in;
    logic [DATA_WIDTH-1:0]     multiplicand;
    logic [DATA_WIDTH-1:0]     multiplier;
    logic                      busy;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   product;
    logic                      ov_flag;
    logic [2:0]                booth_digit;

    modport master (
        output enable_in, multiplicand, multiplier,
        input  busy, done, product, ov_flag, booth_digit
    );

    modport slave (
        input  enable_in, multiplicand, multiplier,
        output busy, done, product, ov_flag, booth_digit
    );
endinterface

// File: rtl/booth_radix4_mul_seq.sv
// Sequential unsigned multiplier that consumes one radix-4 Booth digit per clock.
// Defining MUL_OVERFLOW_FLAG_EN builds ov_flag (upper product half nonzero); otherwise ov_flag is tied low.
//
// state | meaning
// IDLE  | waiting for enable_in; operands are captured on the start edge
// CALC  | one Booth digit per cycle, K = DATA_WIDTH/2 + 1 iterations
// DONE  | one-cycle done pulse; enable_in here restarts immediately
module booth_radix4_mul_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    booth_radix4_mul_seq_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int K     = W/2 + 1;
    localparam int CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [W+2:0]    acc_q, acc_d;
    logic [W+1:0]           mreg_q, mreg_d;
    logic                   prev_q, prev_d;
    logic [W-1:0]           mcand_q, mcand_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2*W-1:0]         product_q, product_d;
    logic                   load_result;

    logic [2:0]             digit;
    logic signed [W+2:0]    mag;
    logic signed [W+2:0]    addend;
    logic signed [W+2:0]    sum;
    logic                   start;

    // Booth digit from the two live multiplier bits plus the bit shifted out last iteration.
    always_comb begin
        digit = 3'd0;
        unique case ({mreg_q[1:0], prev_q})
            3'b000, 3'b111: digit = 3'd0;
            3'b001, 3'b010: digit = 3'd1;
            3'b011:         digit = 3'd2;
            3'b100:         digit = 3'b110;
            3'b101, 3'b110: digit = 3'b111;
            default:        digit = 3'd0;
        endcase
    end

    always_comb begin
        mag    = {3'b000, mcand_q};
        addend = '0;
        unique case (digit)
            3'd1:    addend = mag;
            3'd2:    addend = mag <<< 1;
            3'b111:  addend = -mag;
            3'b110:  addend = -(mag <<< 1);
            default: addend = '0;
        endcase
        sum = acc_q + addend;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mreg_d      = mreg_q;
        prev_d      = prev_q;
        mcand_d     = mcand_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        product_d   = product_q;
        load_result = 1'b0;
        start       = bus.enable_in && (state_q != ST_CALC);

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_CALC: begin
                acc_d  = {sum[W+2], sum[W+2], sum[W+2:2]};
                mreg_d = {sum[1:0], mreg_q[W+1:2]};
                prev_d = mreg_q[1];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(K-1)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    load_result = 1'b1;
                    // After 2K shifts the low product bits have fully displaced the multiplier.
                    product_d   = {acc_d[W-3:0], mreg_d};
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (start) begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            mreg_d  = {2'b00, bus.multiplier};
            prev_d  = 1'b0;
            mcand_d = bus.multiplicand;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mreg_q    <= '0;
            prev_q    <= 1'b0;
            mcand_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mreg_q    <= mreg_d;
            prev_q    <= prev_d;
            mcand_q   <= mcand_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

`ifdef MUL_OVERFLOW_FLAG_EN
    logic ov_q, ov_d;

    always_comb begin
        ov_d = ov_q;
        if (load_result) ov_d = |product_d[2*W-1:W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ov_q <= 1'b0;
        else          ov_q <= ov_d;
    end

    assign bus.ov_flag = ov_q;
`else
    assign bus.ov_flag = 1'b0;
`endif

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.product     = product_q;
    assign bus.booth_digit = (state_q == ST_CALC) ? digit : 3'd0;
endmodule

// File: tb/tb_booth_radix4_mul_seq.sv
// Bench for booth_radix4_mul_seq: vector table, corner sequences and a random sweep,
// with results checked through a scoreboard queue when done pulses.
module tb_booth_radix4_mul_seq;
    localparam int W = 8;
    localparam int K = W/2 + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    booth_radix4_mul_seq_if #(.DATA_WIDTH(W)) bus ();

    booth_radix4_mul_seq #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0]   prod_ov_dummy;
        logic [2*W-1:0] prod;
        logic           ov;
    } exp_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [2:0] last_digits[K];

    function automatic logic ov_of(input logic [2*W-1:0] p);
`ifdef MUL_OVERFLOW_FLAG_EN
        return |p[2*W-1:W];
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result checking happens whenever the DUT pulses done.
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: product %0h with empty scoreboard at %0t", bus.product, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 32'(bus.product), 32'(e.prod));
                check("ov_flag", 32'(bus.ov_flag), 32'(e.ov));
            end
        end
    end

    task automatic push_exp(input logic [2*W-1:0] p);
        exp_t e;
        e.prod_ov_dummy = '0;
        e.prod = p;
        e.ov   = ov_of(p);
        sb.push_back(e);
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
        bus.enable_in    = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        push_exp(p);
        tick();
        bus.enable_in    = 1'b0;
        bus.multiplicand = W'($urandom);
        bus.multiplier   = W'($urandom);
    endtask

    // Full operation from an idle cycle; digits seen in CALC are recorded.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
        start(a, b, p);
        for (int c = 1; c <= K; c++) begin
            last_digits[c-1] = bus.booth_digit;
            check("busy_calc", {30'd0, bus.busy, bus.done}, 32'b10);
            tick();
        end
        check("done_cycle", {30'd0, bus.busy, bus.done}, 32'b01);
        check("digit_done", 32'(bus.booth_digit), 32'd0);
        tick();
        check("idle_after", {29'd0, bus.busy, bus.done, |bus.booth_digit}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{8'h0C, 8'h0A, 16'h0078};
        vecs[2]  = '{8'h00, 8'h55, 16'h0000};
        vecs[3]  = '{8'h55, 8'h00, 16'h0000};
        vecs[4]  = '{8'h07, 8'h09, 16'h003F};
        vecs[5]  = '{8'h80, 8'h02, 16'h0100};
        vecs[6]  = '{8'h12, 8'h34, 16'h03A8};
        vecs[7]  = '{8'h01, 8'h01, 16'h0001};
        vecs[8]  = '{8'hFF, 8'h01, 16'h00FF};
        vecs[9]  = '{8'h01, 8'hFF, 16'h00FF};
        vecs[10] = '{8'hAA, 8'h55, 16'h3872};
        vecs[11] = '{8'h80, 8'h80, 16'h4000};

        bus.enable_in    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        tick();
        tick();
        check("reset_outputs",
              {11'd0, bus.busy, bus.done, bus.ov_flag, bus.booth_digit, bus.product}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].prod);

        // Digit order for 0xFF x 0xFF: -1, 0, 0, 0, +1
        run_op(8'hFF, 8'hFF, 16'hFE01);
        check("digit0", 32'(last_digits[0]), 32'h7);
        check("digit1", 32'(last_digits[1]), 32'h0);
        check("digit2", 32'(last_digits[2]), 32'h0);
        check("digit3", 32'(last_digits[3]), 32'h0);
        check("digit4", 32'(last_digits[4]), 32'h1);

        // Start request while busy must be ignored.
        start(8'h12, 8'h34, 16'h03A8);
        tick();
        tick();
        bus.enable_in    = 1'b1;
        bus.multiplicand = 8'hFF;
        bus.multiplier   = 8'hFF;
        tick();
        bus.enable_in    = 1'b0;
        check("busy_ignored_start", 32'(bus.busy), 32'd1);
        tick();
        tick();
        check("single_done", {30'd0, bus.busy, bus.done}, 32'b01);
        for (int c = 0; c < 8; c++) tick();
        check("idle_after_ignore", {30'd0, bus.busy, bus.done}, 32'd0);

        // enable_in held high: back-to-back results every K+1 cycles.
        bus.enable_in    = 1'b1;
        bus.multiplicand = 8'h80;
        bus.multiplier   = 8'h02;
        for (int r = 0; r < 4; r++) begin
            push_exp(16'h0100);
            for (int c = 1; c <= K + 1; c++) begin
                tick();
                if (c <= K) check("stream_calc", {30'd0, bus.busy, bus.done}, 32'b10);
                else        check("stream_done", {30'd0, bus.busy, bus.done}, 32'b01);
            end
        end
        bus.enable_in = 1'b0;
        tick();
        check("stream_stop", {30'd0, bus.busy, bus.done}, 32'd0);

        // Reset in the middle of an operation discards it.
        start(8'h33, 8'h44, 16'h0D8C);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              {11'd0, bus.busy, bus.done, bus.ov_flag, bus.booth_digit, bus.product}, 32'd0);
        sb.delete();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("no_done_after_reset", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        run_op(8'h07, 8'h09, 16'h003F);

        // Random sweep against a plain multiply reference.
        for (int n = 0; n < 1200; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            run_op(a, b, (2*W)'(a) * (2*W)'(b));
        end

        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
